// File: rtl/usb_arb_pkg.sv
// usb_arb_pkg: shared types and the round-robin search helper for the USB frame arbiter
package usb_arb_pkg;
  localparam int MAX_SRC = 8;
  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic  last;
    byte_t data;
  } fifo_word_t;
  typedef enum logic [1:0] {IDLE, SEND, GAP} arb_state_t;
  // First requester after 'last' walking upward modulo n; returns 'last' when nobody requests.
  // Walking k downward lets the nearest candidate overwrite the farther ones.
  function automatic int rr_next(input logic [MAX_SRC-1:0] req, input int last, input int n);
    int sel;
    int idx;
    sel = last;
    for (int k = MAX_SRC; k >= 1; k--) begin
      idx = (last + k) % n;
      if (k <= n && req[idx[2:0]]) sel = idx;
    end
    return sel;
  endfunction
endpackage

// File: rtl/ble_src_fifo.sv
// ble_src_fifo: per-source store-and-forward FIFO of {last, data} words with a complete-packet counter
module ble_src_fifo
  import usb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [8:0]    wr_word_i,
  input  logic          rd_i,
  output logic [8:0]    rd_word_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] pkt_cnt_o
);
  fifo_word_t    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_cnt, r_pkt;
  fifo_word_t    w_wr_word, w_rd_word;
  assign w_wr_word = wr_word_i;
  assign w_rd_word = r_mem[r_rd_ptr];
  assign rd_word_o = w_rd_word;
  assign full_o    = r_cnt == CW'(FIFO_DEPTH);
  assign empty_o   = r_cnt == '0;
  assign pkt_cnt_o = r_pkt;
  // storage array, no reset needed since occupancy is tracked separately
  always_ff @(posedge clk_i)
    if (wr_i) r_mem[r_wr_ptr] <= w_wr_word;
  // pointers wrap naturally at the power-of-two depth; packet count tracks complete packets held
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_pkt    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(wr_i);
      r_rd_ptr <= r_rd_ptr + AW'(rd_i);
      r_cnt    <= r_cnt + CW'(wr_i) - CW'(rd_i);
      r_pkt    <= r_pkt + CW'(wr_i & w_wr_word.last) - CW'(rd_i & w_rd_word.last);
    end
endmodule

// File: rtl/usb_frame_arbiter.sv
// usb_frame_arbiter: packet-granular round-robin arbiter sharing one USB byte stream between analyzer sources
module usb_frame_arbiter
  import usb_arb_pkg::*;
#(
  parameter int NB_SRC     = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int GAP_CYCLES = 1,
  localparam int GW = $clog2(NB_SRC),
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int TW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NB_SRC-1:0]     src_valid_i,
  input  logic [NB_SRC*8-1:0]   src_data_i,
  input  logic [NB_SRC-1:0]     src_last_i,
  output logic [NB_SRC-1:0]     src_ready_o,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  output logic                  frame_o,
  output logic [GW-1:0]         grant_o,
  output logic [NB_SRC-1:0]     ovf_o
);
  arb_state_t        r_state, w_state_n;
  logic [GW-1:0]     r_grant, w_grant_n;
  logic [TW-1:0]     r_gap, w_gap_n;
  byte_t             r_data, w_data_n;
  logic              r_valid, w_valid_n;
  logic              r_frame, w_frame_n;
  logic              r_rdy_en;
  logic [NB_SRC-1:0] r_ovf;
  logic [NB_SRC-1:0] w_full, w_empty, w_elig, w_wr, w_rd;
  logic [8:0]        w_rd_word [NB_SRC];
  logic [CW-1:0]     w_pkt [NB_SRC];
  fifo_word_t        w_cur;
  for (genvar i = 0; i < NB_SRC; i++) begin : g_src
    assign w_wr[i]        = src_valid_i[i] & src_ready_o[i];
    assign w_rd[i]        = (r_state == SEND) && (r_grant == GW'(i)) && !w_empty[i];
    assign src_ready_o[i] = r_rdy_en & (~w_full[i] | w_rd[i]);
    assign w_elig[i]      = (w_pkt[i] != '0) | w_full[i];
    ble_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_i      (w_wr[i]),
      .wr_word_i ({src_last_i[i], src_data_i[i*8 +: 8]}),
      .rd_i      (w_rd[i]),
      .rd_word_o (w_rd_word[i]),
      .full_o    (w_full[i]),
      .empty_o   (w_empty[i]),
      .pkt_cnt_o (w_pkt[i])
    );
  end
  assign w_cur   = w_rd_word[r_grant];
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign frame_o = r_frame;
  assign grant_o = r_grant;
  assign ovf_o   = r_ovf;
  // next state and next registered outputs; an empty FIFO in SEND keeps the frame open without data
  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_gap_n   = r_gap;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_frame_n = 1'b0;
    case (r_state)
      IDLE: if (|w_elig) begin
        w_grant_n = GW'(rr_next(MAX_SRC'(w_elig), int'(r_grant), NB_SRC));
        w_state_n = SEND;
      end
      SEND: begin
        w_frame_n = 1'b1;
        if (|w_rd) begin
          w_valid_n = 1'b1;
          w_data_n  = w_cur.data;
          w_state_n = w_cur.last ? GAP : SEND;
          w_gap_n   = '0;
        end
      end
      GAP: begin
        w_gap_n   = (r_gap == TW'(GAP_CYCLES - 1)) ? '0 : r_gap + 1'b1;
        w_state_n = (r_gap == TW'(GAP_CYCLES - 1)) ? IDLE : GAP;
      end
      default: w_state_n = IDLE;
    endcase
  end
  // state, output registers, ready enable after reset and sticky overflow on dropped writes
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_state  <= IDLE;
      r_grant  <= GW'(NB_SRC - 1);
      r_gap    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_frame  <= 1'b0;
      r_rdy_en <= 1'b0;
      r_ovf    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_grant  <= w_grant_n;
      r_gap    <= w_gap_n;
      r_data   <= w_data_n;
      r_valid  <= w_valid_n;
      r_frame  <= w_frame_n;
      r_rdy_en <= 1'b1;
      r_ovf    <= r_ovf | (src_valid_i & ~src_ready_o);
    end
endmodule

// File: tb/tb_usb_frame_arbiter.sv
// tb_usb_frame_arbiter: directed table-driven and sequence checks of the USB frame arbiter
module tb_usb_frame_arbiter;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  src_valid_i, src_last_i, src_ready_o, ovf_o;
  logic [31:0] src_data_i;
  logic [7:0]  data_o;
  logic        valid_o, frame_o;
  logic [1:0]  grant_o;
  typedef struct { int g; int d; int cyc; } cap_t;
  typedef struct { int src; int len; int base; int exp_grant; int exp_lat; int exp_flen; } vec_t;
  cap_t cap_q [$];
  int   frame_q [$];
  int   gap_q [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_e = 0;
  int   f_len = 0;
  int   low_len = 0;
  int   n_hold = 0;
  bit   seen = 0;
  vec_t tbl [4];
  usb_frame_arbiter #(.NB_SRC(4), .FIFO_DEPTH(8), .GAP_CYCLES(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .src_valid_i (src_valid_i),
    .src_data_i  (src_data_i),
    .src_last_i  (src_last_i),
    .src_ready_o (src_ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_o     (frame_o),
    .grant_o     (grant_o),
    .ovf_o       (ovf_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_i) begin
      f_len = 0;
      low_len = 0;
    end else begin
      if (valid_o) begin
        cap_q.push_back('{int'(grant_o), int'(data_o), cyc});
        chk("valid_in_frame", int'(frame_o), 1);
      end
      if (frame_o && !valid_o) n_hold++;
      if (frame_o) begin
        if (f_len == 0 && seen) gap_q.push_back(low_len);
        f_len++;
        low_len = 0;
      end else begin
        if (f_len != 0) begin
          frame_q.push_back(f_len);
          seen = 1;
        end
        f_len = 0;
        low_len++;
      end
    end
  end
  task automatic clear_q();
    cap_q.delete();
    frame_q.delete();
    gap_q.delete();
  endtask
  task automatic drive_cycle(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    @(negedge clk);
    src_valid_i = v;
    src_last_i  = l;
    src_data_i  = d;
  endtask
  task automatic send_pkt(input int s, input int len, input int base, input int pause_at, input int pause_len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == pause_at) begin
        src_valid_i = '0;
        repeat (pause_len) @(negedge clk);
      end
      for (int t = 0; t < 50 && !src_ready_o[s]; t++) begin
        src_valid_i = '0;
        @(negedge clk);
      end
      src_valid_i = '0;
      src_last_i  = '0;
      src_valid_i[s] = 1'b1;
      src_last_i[s]  = (k == len - 1);
      src_data_i[s*8 +: 8] = 8'(base + k);
      last_e = cyc + 1;
    end
    @(negedge clk);
    src_valid_i = '0;
    src_last_i  = '0;
  endtask
  task automatic wait_bytes(input int n, input int budget, input string nm);
    for (int t = 0; t < budget && cap_q.size() < n; t++) @(negedge clk);
    chk(nm, int'(cap_q.size() >= n), 1);
  endtask
  initial begin
    int fg [10];
    int fd [10];
    int rr_src [3];
    fg = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    fd = '{'h40, 'h41, 'h42, 'h43, 'h50, 'h51, 'h44, 'h45, 'h46, 'h47};
    rr_src = '{0, 1, 3};
    tbl[0] = '{2, 5, 'h10, 2, 2, 5};
    tbl[1] = '{0, 1, 'hA0, 0, 2, 1};
    tbl[2] = '{1, 8, 'h30, 1, 2, 8};
    tbl[3] = '{3, 2, 'hF0, 3, 2, 2};
    rst_i = 1'b0;
    src_valid_i = '0;
    src_last_i = '0;
    src_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_frame", int'(frame_o), 0);
    chk("rst_ready", int'(src_ready_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    chk("rst_grant", int'(grant_o), 3);
    rst_i = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(src_ready_o), 'hF);
    for (int i = 0; i < 4; i++) begin
      clear_q();
      send_pkt(tbl[i].src, tbl[i].len, tbl[i].base, -1, 0);
      wait_bytes(tbl[i].len, 40, "tbl_wait");
      repeat (4) @(negedge clk);
      chk("tbl_latency", cap_q[0].cyc - last_e, tbl[i].exp_lat);
      chk("tbl_count", cap_q.size(), tbl[i].len);
      for (int k = 0; k < tbl[i].len; k++) begin
        chk("tbl_data", cap_q[k].d, (tbl[i].base + k) & 'hFF);
        chk("tbl_grant", cap_q[k].g, tbl[i].exp_grant);
        chk("tbl_consecutive", cap_q[k].cyc - cap_q[0].cyc, k);
      end
      chk("tbl_frame_len", frame_q.size() > 0 ? frame_q[0] : -1, tbl[i].exp_flen);
    end
    clear_q();
    for (int k = 0; k < 3; k++)
      drive_cycle(4'b1011, (k == 2) ? 4'b1011 : 4'b0000, {8'(8'h28 + k), 8'h00, 8'(8'h24 + k), 8'(8'h20 + k)});
    drive_cycle(4'b0, 4'b0, 32'h0);
    wait_bytes(9, 80, "rr_wait");
    repeat (4) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      chk("rr_grant", cap_q[k].g, rr_src[k / 3]);
      chk("rr_data", cap_q[k].d, 'h20 + 4 * (k / 3) + k % 3);
    end
    chk("rr_gap_count", gap_q.size(), 3);
    chk("rr_gap1", gap_q.size() > 1 ? gap_q[1] : -1, 2);
    chk("rr_gap2", gap_q.size() > 2 ? gap_q[2] : -1, 2);
    clear_q();
    for (int k = 0; k < 4; k++)
      drive_cycle(4'b0001, {3'b0, k == 3}, {24'h0, 8'(8'h40 + k)});
    for (int k = 0; k < 4; k++)
      drive_cycle({2'b0, k < 2, 1'b1}, {2'b0, k == 1, k == 3}, {16'h0, 8'(8'h50 + k), 8'(8'h44 + k)});
    drive_cycle(4'b0, 4'b0, 32'h0);
    wait_bytes(10, 80, "fair_wait");
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk("fair_grant", cap_q[k].g, fg[k]);
      chk("fair_data", cap_q[k].d, fd[k]);
    end
    clear_q();
    n_hold = 0;
    send_pkt(0, 12, 'h60, 10, 12);
    wait_bytes(12, 100, "ct_wait");
    repeat (4) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      chk("ct_data", cap_q[k].d, 'h60 + k);
      chk("ct_grant", cap_q[k].g, 0);
    end
    chk("ct_early_start", int'(cap_q[0].cyc < last_e), 1);
    chk("ct_one_frame", frame_q.size(), 1);
    chk("ct_frame_held", int'(n_hold > 0), 1);
    chk("ct_ovf", int'(ovf_o), 0);
    clear_q();
    for (int k = 0; k < 8; k++)
      drive_cycle(4'b0010, 4'b0, {16'h0, 8'(8'h80 + k), 8'h0});
    drive_cycle(4'b0010, 4'b0, {16'h0, 8'hEE, 8'h0});
    chk("ovf_ready_low", int'(src_ready_o[1]), 0);
    chk("ovf_not_yet", int'(ovf_o), 0);
    drive_cycle(4'b0010, 4'b0010, {16'h0, 8'h88, 8'h0});
    chk("ovf_set", int'(ovf_o), 'h2);
    chk("ovf_others_ready", int'(src_ready_o), 'hF);
    drive_cycle(4'b0, 4'b0, 32'h0);
    wait_bytes(9, 60, "ovf_wait");
    repeat (4) @(negedge clk);
    chk("ovf_count", cap_q.size(), 9);
    for (int k = 0; k < 9; k++) begin
      chk("ovf_data", cap_q[k].d, 'h80 + k);
      chk("ovf_grant", cap_q[k].g, 1);
    end
    chk("ovf_sticky", int'(ovf_o), 'h2);
    clear_q();
    send_pkt(2, 6, 'hA0, -1, 0);
    wait_bytes(3, 20, "mid_wait");
    rst_i = 1'b0;
    #1;
    chk("mid_valid", int'(valid_o), 0);
    chk("mid_frame", int'(frame_o), 0);
    chk("mid_data", int'(data_o), 0);
    chk("mid_grant", int'(grant_o), 3);
    chk("mid_ovf", int'(ovf_o), 0);
    chk("mid_ready", int'(src_ready_o), 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    clear_q();
    repeat (20) @(negedge clk);
    chk("mid_quiet", cap_q.size(), 0);
    chk("mid_frame_low", int'(frame_o), 0);
    clear_q();
    send_pkt(0, 2, 'hB0, -1, 0);
    wait_bytes(2, 20, "post_wait");
    repeat (4) @(negedge clk);
    chk("post_latency", cap_q[0].cyc - last_e, 2);
    chk("post_grant", cap_q[0].g, 0);
    chk("post_data0", cap_q[0].d, 'hB0);
    chk("post_data1", cap_q[1].d, 'hB1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
